prescaler_bank: RTL and testbench



---
 rtl/prescaler_bank_pkg.sv | 22 ++
 rtl/prescaler_bank_if.sv | 18 +
 rtl/prescaler_bank_channel.sv | 125 ++++++++++++
 rtl/prescaler_bank.sv | 62 ++++++
 tb/tb_prescaler_bank.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prescaler_bank_pkg.sv
// Shared types and helpers for the prescaler bank: channel FSM states,
// the smallest legal divisor and the high/low phase split of a divisor.
package prescaler_bank_pkg;

    typedef enum logic [1:0] {OFF, HIGH, LOW} prescaler_state_t;

    localparam int MIN_DIVISOR = 2;

    typedef struct packed {
        logic [31:0] high;
        logic [31:0] low;
    } phase_split_t;

    // High phase gets the smaller half, so odd divisors spend the extra cycle low.
    function automatic phase_split_t phase_split(input logic [31:0] divisor);
        phase_split_t s;
        s.high = divisor >> 1;
        s.low  = divisor - s.high;
        return s;
    endfunction

endpackage

// File: rtl/prescaler_bank_if.sv
// Divisor write port of the prescaler bank.
// Handshake: a write transfers on any cycle where cfg_valid && cfg_ready; cfg_ready is
// combinational from cfg_channel and may change whenever cfg_channel changes.
interface prescaler_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_channel;
    logic [WIDTH-1:0] cfg_divisor;

    modport master (output cfg_valid, output cfg_channel, output cfg_divisor, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_channel, input cfg_divisor, output cfg_ready);

endinterface

// File: rtl/prescaler_bank_channel.sv
// One divider channel: OFF/HIGH/LOW FSM with a reload-at-zero counter.
// Divisor changes while running are parked in a pending slot until the period ends.
module prescaler_bank_channel
    import prescaler_bank_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int DEFAULT_DIVISOR = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             pending_o,
    output logic             slow_clock_o,
    output logic             tick_o,
    output logic             busy_o,
    output prescaler_state_t state_o
);

    prescaler_state_t state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             slow_q, busy_q;
    logic [WIDTH-1:0] sel_div;
    phase_split_t     split;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            active_q <= WIDTH'(DEFAULT_DIVISOR);
            pdiv_q   <= WIDTH'(DEFAULT_DIVISOR);
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            slow_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pdiv_q   <= pdiv_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            slow_q   <= (state_d == HIGH);
            busy_q   <= (state_d != OFF);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        pdiv_d   = pdiv_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        // Divisor governing the next phase load: the boundary divisor in LOW,
        // a same-cycle write when starting from OFF, otherwise the active one.
        if (state_q == LOW)
            sel_div = pend_q ? pdiv_q : active_q;
        else if (state_q == OFF && wr_en_i)
            sel_div = wr_div_i;
        else
            sel_div = active_q;
        split = phase_split(32'(sel_div));

        case (state_q)
            OFF: begin
                if (enable_i) begin
                    state_d = HIGH;
                    cnt_d   = WIDTH'(split.high - 32'd1);
                    tick_d  = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = WIDTH'(split.low - 32'd1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    active_d = sel_div;
                    pend_d   = 1'b0;
                    if (enable_i) begin
                        state_d = HIGH;
                        cnt_d   = WIDTH'(split.high - 32'd1);
                        tick_d  = 1'b1;
                    end else begin
                        state_d = OFF;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase

        // Applied after the boundary so a colliding write waits for the next one.
        if (wr_en_i) begin
            if (state_q == OFF) begin
                active_d = wr_div_i;
            end else begin
                pdiv_d = wr_div_i;
                pend_d = 1'b1;
            end
        end
    end

    assign pending_o    = pend_q;
    assign slow_clock_o = slow_q;
    assign tick_o       = tick_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;

endmodule

// File: rtl/prescaler_bank.sv
// Bank of independent programmable clock dividers sharing one fast clock,
// with a single divisor write port decoded to the target channel.
module prescaler_bank
    import prescaler_bank_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int WIDTH           = 16,
    parameter int DEFAULT_DIVISOR = 2
) (
    input  logic                      quick_clock_i,
    input  logic                      reset_i,
    input  logic [CHANNELS-1:0]       enable_i,
    prescaler_bank_if.slave           cfg_if,
    output logic [CHANNELS-1:0]       slow_clock_o,
    output logic [CHANNELS-1:0]       tick_o,
    output logic [CHANNELS-1:0]       busy_o,
    output prescaler_state_t [CHANNELS-1:0] state_dbg_o
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_en;
    logic                cfg_ready_w;
    logic [WIDTH-1:0]    wr_div;

    assign wr_div = (cfg_if.cfg_divisor < WIDTH'(MIN_DIVISOR)) ? WIDTH'(MIN_DIVISOR)
                                                               : cfg_if.cfg_divisor;

    // Out-of-range channel indices match nothing: ready stays high and the write is dropped.
    always_comb begin
        cfg_ready_w = 1'b1;
        wr_en       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_if.cfg_channel == CH_W'(i)) begin
                cfg_ready_w = ~pending[i];
                wr_en[i]    = cfg_if.cfg_valid & ~pending[i];
            end
        end
    end

    assign cfg_if.cfg_ready = cfg_ready_w;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        prescaler_bank_channel #(
            .WIDTH           (WIDTH),
            .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
        ) u_ch (
            .clk_i        (quick_clock_i),
            .rst_i        (reset_i),
            .enable_i     (enable_i[g]),
            .wr_en_i      (wr_en[g]),
            .wr_div_i     (wr_div),
            .pending_o    (pending[g]),
            .slow_clock_o (slow_clock_o[g]),
            .tick_o       (tick_o[g]),
            .busy_o       (busy_o[g]),
            .state_o      (state_dbg_o[g])
        );
    end

endmodule

// File: tb/tb_prescaler_bank.sv
// Self-checking bench for prescaler_bank: directed scenarios plus random traffic,
// compared cycle by cycle against a period-position reference model.
module tb_prescaler_bank;
    import prescaler_bank_pkg::*;

    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int DEF = 2;

    logic                    clk;
    logic                    rst;
    logic [CH-1:0]           en;
    logic [CH-1:0]           slow, tick, busy;
    prescaler_state_t [CH-1:0] state_dbg;

    prescaler_bank_if #(.CHANNELS(CH), .WIDTH(W)) cfg();

    prescaler_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIVISOR(DEF)) dut (
        .quick_clock_i (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .cfg_if        (cfg.slave),
        .slow_clock_o  (slow),
        .tick_o        (tick),
        .busy_o        (busy),
        .state_dbg_o   (state_dbg)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- reference model: each running channel is a position within a period ----
    bit  m_run [CH];
    int  m_pos [CH];
    int  m_n   [CH];
    int  m_act [CH];
    bit  m_pend[CH];
    int  m_pv  [CH];
    logic [3*CH-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_n[i] = DEF;
            m_act[i] = DEF; m_pend[i] = 0; m_pv[i] = DEF;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input bit acc, input int tgt, input int div);
        logic [3*CH-1:0] e;
        int d;
        bit was_run;
        d = (div < 2) ? 2 : div;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            was_run = m_run[i];
            if (acc && tgt == i && !was_run) m_act[i] = d;
            if (was_run) begin
                m_pos[i]++;
                if (m_pos[i] == m_n[i]) begin
                    if (m_pend[i]) begin m_act[i] = m_pv[i]; m_pend[i] = 0; end
                    if (en[i]) begin m_pos[i] = 0; m_n[i] = m_act[i]; end
                    else m_run[i] = 0;
                end
            end else if (en[i]) begin
                m_run[i] = 1; m_pos[i] = 0; m_n[i] = m_act[i];
            end
            if (acc && tgt == i && was_run) begin m_pend[i] = 1; m_pv[i] = d; end
            e[i]        = m_run[i] && (m_pos[i] < m_n[i] / 2);
            e[CH + i]   = m_run[i] && (m_pos[i] == 0);
            e[2*CH + i] = m_run[i];
        end
        exp_q.push_back(e);
    endtask

    // ---- driver: one clock cycle with the currently driven inputs ----
    task automatic do_cycle();
        int ch;
        bit exp_ready;
        bit acc;
        logic [3*CH-1:0] e;
        #2;
        ch = int'(cfg.cfg_channel);
        exp_ready = (ch >= CH) ? 1'b1 : !m_pend[ch];
        check_eq("cfg_ready", 32'(cfg.cfg_ready), 32'(exp_ready));
        acc = cfg.cfg_valid && exp_ready && (ch < CH);
        @(posedge clk);
        model_step(acc, ch, int'(cfg.cfg_divisor));
        #1;
        e = exp_q.pop_front();
        for (int i = 0; i < CH; i++) begin
            check_eq($sformatf("slow%0d", i), 32'(slow[i]), 32'(e[i]));
            check_eq($sformatf("tick%0d", i), 32'(tick[i]), 32'(e[CH + i]));
            check_eq($sformatf("busy%0d", i), 32'(busy[i]), 32'(e[2*CH + i]));
        end
    endtask

    task automatic write_cfg(input int ch, input int div);
        cfg.cfg_valid   = 1'b1;
        cfg.cfg_channel = 2'(ch);
        cfg.cfg_divisor = W'(div);
        do_cycle();
        cfg.cfg_valid   = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) do_cycle();
    endtask

    // p < 0 waits for the channel to be off; otherwise for that period position.
    task automatic run_until(input int ch, input int p, input int budget);
        int  n;
        bit  reached;
        n = 0;
        reached = (p < 0) ? !m_run[ch] : (m_run[ch] && m_pos[ch] == p);
        while (!reached && n < budget) begin
            do_cycle();
            n++;
            reached = (p < 0) ? !m_run[ch] : (m_run[ch] && m_pos[ch] == p);
        end
        check_eq($sformatf("wait_bound_ch%0d", ch), 32'(reached), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_slow"}, 32'(slow), 32'd0);
        check_eq({tag, "_tick"}, 32'(tick), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ticks;
        rst = 1'b1;
        en  = '0;
        cfg.cfg_valid   = 1'b0;
        cfg.cfg_channel = '0;
        cfg.cfg_divisor = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        check_eq("reset_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;

        // Default divisor 2: toggles every cycle
        en[0] = 1'b1;
        run(8);

        // Async reset in the middle of a HIGH phase
        run_until(0, 0, 4);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 check_all_zero("rst_held");
        en = '0;
        rst = 1'b0;
        model_reset();

        // Odd divisor on channel 1 written while OFF
        write_cfg(1, 5);
        en[1] = 1'b1;
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            do_cycle();
            ticks += int'(tick[1]);
        end
        check_eq("ch1_ticks_100", 32'(ticks), 32'd20);

        // Glitch-free update mid-HIGH on channel 2
        write_cfg(2, 8);
        en[2] = 1'b1;
        run_until(2, 2, 20);
        write_cfg(2, 3);
        run(30);

        // Boundary collision on channel 0: write lands in the last LOW cycle
        write_cfg(0, 4);
        en[0] = 1'b1;
        run_until(0, 3, 20);
        write_cfg(0, 6);
        run(30);

        // Disable mid-HIGH on channel 1 with N=10
        en[1] = 1'b0;
        run_until(1, -1, 20);
        write_cfg(1, 10);
        en[1] = 1'b1;
        run_until(1, 2, 20);
        en[1] = 1'b0;
        run(15);
        check_eq("ch1_busy_after_disable", 32'(busy[1]), 32'd0);
        check_eq("ch1_slow_after_disable", 32'(slow[1]), 32'd0);

        // Divisors 0 and 1 clamp to 2
        en[2] = 1'b0;
        run_until(2, -1, 20);
        write_cfg(2, 0);
        en[2] = 1'b1;
        run(10);
        en[2] = 1'b0;
        run_until(2, -1, 20);
        write_cfg(2, 1);
        en[2] = 1'b1;
        run(10);

        // Out-of-range channel index is accepted and ignored
        for (int k = 0; k < 3; k++) write_cfg(3, 9);
        run(20);

        // Writes on alternate cycles to every channel
        en = '1;
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) write_cfg((k / 2) % CH, $urandom_range(2, 9));
            else do_cycle();
        end
        run(40);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, CH - 1)] ^= 1'b1;
            cfg.cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg.cfg_channel = 2'($urandom_range(0, 3));
            cfg.cfg_divisor = W'($urandom_range(0, 12));
            do_cycle();
        end
        cfg.cfg_valid = 1'b0;
        run(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
